if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: DEPTH, 2, combined limit on in-flight requests plus buffered instructions.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 redirect_valid  input  1  branch/jump redirect request from later stages.
REQ-006 redirect_pc  input  32  redirect target; bits [1:0] ignored, treated as zero.
REQ-007 stall  input  1  downstream IF/IM register cannot accept this cycle.
REQ-008 imem_req_valid  output  1  fetch request to instruction memory.
REQ-009 imem_req_ready  input  1  memory accepts request this cycle.
REQ-010 imem_req_addr  output  32  word-aligned fetch address.
REQ-011 imem_rsp_valid  input  1  instruction data returned, in request order, latency >= 1 cycle.
REQ-012 imem_rsp_data  input  32  returned instruction word.
REQ-013 op_en_out  output  1  valid instruction presented to IF/IM stage (drives op_en_in there).
REQ-014 pc_out  output  32  PC of presented instruction.
REQ-015 instr_out  output  32  presented instruction word.

Function
REQ-016 States: RUN (issue/accept) and FLUSH (discard stale responses); encoded as a 1-bit enum.
REQ-017 Request handshake: transfer occurs when imem_req_valid && imem_req_ready; imem_req_addr and imem_req_valid are held stable until transfer or redirect.
REQ-018 imem_req_valid = state==RUN && !redirect_valid && (outstanding + fifo_count) < DEPTH.
REQ-019 On each request transfer, fetch_pc advances by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0) and outstanding increments.
REQ-020 In RUN, each imem_rsp_valid pushes {pc, data} into the buffer; pc is taken from an internal in-order PC tag queue, not recomputed.
REQ-021 op_en_out = buffer non-empty && !stall && !redirect_valid; pc_out/instr_out = buffer head, 0 when op_en_out is 0.
REQ-022 Buffer pops in the cycle op_en_out is 1; push and pop in the same cycle are both honoured (count unchanged).
REQ-023 redirect_valid in any state: fetch_pc <= redirect_pc & ~3, buffer flushed, no request issued that cycle; next state FLUSH if outstanding (after same-cycle response) > 0, else RUN.
REQ-024 FLUSH: imem_rsp_valid decrements outstanding and data is discarded; transition to RUN in the cycle after outstanding reaches 0; no requests in FLUSH.
REQ-025 A second redirect during FLUSH overwrites fetch_pc and stays in FLUSH.
REQ-026 imem_rsp_valid with outstanding == 0 is a protocol violation; ignored, assertion fires.
REQ-027 Counters sized $clog2(DEPTH+1) bits; outstanding + fifo_count never exceeds DEPTH.
REQ-028 First request issues in the first cycle after reset deassertion.

Reset
REQ-029 reset low asynchronously forces: state=RUN, fetch_pc=RESET_PC, outstanding=0, buffer empty, tag queue empty.
REQ-030 Outputs during reset: imem_req_valid=0, op_en_out=0, pc_out=0, instr_out=0, imem_req_addr=RESET_PC.
REQ-031 Responses for requests issued before a mid-operation reset are the environment's responsibility; none are captured after reset.

Structure
REQ-032 riscv_pkg holds XLEN=32, INSTR_NOP=32'h0000_0013, and the fetch_state_t enum {RUN, FLUSH}.
REQ-033 One sub-module: fetch_fifo, parameterised by DEPTH and WIDTH, with flush, push, pop, full, empty, count; instantiated for the {pc,instr} buffer; the PC tag queue reuses it.
REQ-034 Target size 150-300 lines total.

Verification
REQ-035 Reset release, imem_req_ready=1, 1-cycle response returning 32'h0000_0013 -> requests to 0x0, 0x4, 0x8; op_en_out=1 with pc_out 0x0, 0x4 in consecutive cycles.
REQ-036 stall=1 for 5 cycles with ready=1 -> at most 2 requests outstanding/buffered; imem_req_valid=0 until stall drops; no instruction lost or duplicated.
REQ-037 Redirect to 0x0000_1002 with 2 outstanding -> FLUSH; both responses dropped; next request addr 0x0000_1000; first op_en_out carries pc_out 0x1000.
REQ-038 imem_req_ready=0 for 3 cycles -> imem_req_addr stable at 0x8, then transfer; fetch_pc advances exactly once.
REQ-039 RESET_PC=32'hFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000.
REQ-040 reset asserted mid-FLUSH -> all outputs zero immediately (asynchronously); after release, fetch restarts at RESET_PC in RUN.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end types and constants for the fetch unit.
// Holds the machine width, the canonical NOP encoding and the fetch FSM state type.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    // Instruction fetches are always 32-bit aligned; the low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a combinational head, synchronous flush and
// simultaneous push/pop; used for both the instruction buffer and the PC tag queue.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_data,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_head,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Explicit wrap so non-power-of-two depths behave.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: issues in-order word fetches, buffers returned words with
// their PCs, presents them to the IF/IM stage and drains stale responses after redirects.
module if_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             stall,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [XLEN-1:0]  imem_rsp_data,
    output logic             op_en_out,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  instr_out
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    logic [XLEN-1:0]     r_fetch_pc;
    logic [CW-1:0]       r_outstanding;
    logic [CW-1:0]       w_outstanding_next;
    logic [CW:0]         w_inflight;
    logic                w_req_xfer;
    logic                w_rsp_ok;

    logic                w_buf_push;
    logic                w_buf_full;
    logic                w_buf_empty;
    logic [CW-1:0]       w_buf_count;
    logic [2*XLEN-1:0]   w_buf_head;

    logic                w_tag_pop;
    logic                w_tag_full;
    logic                w_tag_empty;
    logic [CW-1:0]       w_tag_count;
    logic [XLEN-1:0]     w_tag_head;

    // Gating with reset keeps the request line low while reset is held.
    assign w_inflight     = {1'b0, r_outstanding} + {1'b0, w_buf_count};
    assign imem_req_valid = reset && (r_state == RUN) && !redirect_valid
                            && (w_inflight < (CW+1)'(DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_xfer     = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding are a protocol violation and are dropped.
    assign w_rsp_ok   = imem_rsp_valid && (r_outstanding != '0);
    assign w_tag_pop  = w_rsp_ok && (r_state == RUN);
    assign w_buf_push = w_tag_pop && !redirect_valid;

    assign w_outstanding_next = r_outstanding + CW'(w_req_xfer) - CW'(w_rsp_ok);

    assign op_en_out = !w_buf_empty && !stall && !redirect_valid;
    assign pc_out    = op_en_out ? w_buf_head[2*XLEN-1:XLEN] : '0;
    assign instr_out = op_en_out ? w_buf_head[XLEN-1:0]      : '0;

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = (w_outstanding_next != '0) ? FLUSH : RUN;
        end else if ((r_state == FLUSH) && (w_outstanding_next == '0)) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            if (redirect_valid) begin
                r_fetch_pc <= word_align(redirect_pc);
            end else if (w_req_xfer) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_instr_buf (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (redirect_valid),
        .i_push      (w_buf_push),
        .i_push_data ({w_tag_head, imem_rsp_data}),
        .i_pop       (op_en_out),
        .o_head      (w_buf_head),
        .o_full      (w_buf_full),
        .o_empty     (w_buf_empty),
        .o_count     (w_buf_count)
    );

    // PC of each in-flight request, consumed in order as responses return.
    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_pc_tags (
        .clk         (clk),
        .reset       (reset),
        .i_flush     (redirect_valid),
        .i_push      (w_req_xfer),
        .i_push_data (r_fetch_pc),
        .i_pop       (w_tag_pop),
        .o_head      (w_tag_head),
        .o_full      (w_tag_full),
        .o_empty     (w_tag_empty),
        .o_count     (w_tag_count)
    );

    a_rsp_expected: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (r_outstanding != '0));

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(w_buf_full && w_buf_push && !op_en_out) && !(w_tag_full && w_req_xfer && !w_tag_pop));

    a_tag_in_sync: assert property (@(posedge clk) disable iff (!reset)
        (r_state == RUN) |-> ((w_tag_count == r_outstanding) && (w_buf_push -> !w_tag_empty)));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: a per-cycle vector table for the streaming case
// plus hand-written sequences for back-pressure, redirect/flush, wrap and async reset.
module tb_if_fetch_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        op_en_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    // Second instance checks the address wrap from the top of memory; it never gets responses.
    logic        redirect_valid2 = 1'b0;
    logic [31:0] redirect_pc2    = 32'h0;
    logic        stall2          = 1'b0;
    logic        imem_req_ready2 = 1'b1;
    logic        imem_rsp_valid2 = 1'b0;
    logic [31:0] imem_rsp_data2  = 32'h0;
    logic        imem_req_valid2;
    logic [31:0] imem_req_addr2;
    logic        op_en_out2;
    logic [31:0] pc_out2;
    logic [31:0] instr_out2;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .op_en_out(op_en_out), .pc_out(pc_out),
        .instr_out(instr_out)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut2 (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .stall(stall2), .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready2),
        .imem_req_addr(imem_req_addr2), .imem_rsp_valid(imem_rsp_valid2),
        .imem_rsp_data(imem_rsp_data2), .op_en_out(op_en_out2), .pc_out(pc_out2),
        .instr_out(instr_out2)
    );

    typedef struct {
        logic        stall;
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        op;
        logic [31:0] pc;
        logic [31:0] instr;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pend[$];
    logic        rsp_en;
    logic        s_req_valid, s_op_en, s2_valid;
    logic [31:0] s_addr, s_pc, s_instr, s2_addr;
    logic [31:0] exp_next_pc;
    vec_t        vecs[$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a < 32'h100) ? INSTR_NOP : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic vec_t mk(input logic st, input logic rd, input logic rq,
                                input logic [31:0] ad, input logic op,
                                input logic [31:0] pc, input logic [31:0] ins);
        vec_t v;
        v.stall = st; v.ready = rd; v.req = rq; v.addr = ad; v.op = op; v.pc = pc; v.instr = ins;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive memory response, sample at negedge, score deliveries, advance model.
    task automatic tick();
        imem_rsp_valid = rsp_en && (pend.size() > 0);
        imem_rsp_data  = imem_rsp_valid ? mem_data(pend[0]) : 32'h0;
        @(negedge clk);
        s_req_valid = imem_req_valid;
        s_addr      = imem_req_addr;
        s_op_en     = op_en_out;
        s_pc        = pc_out;
        s_instr     = instr_out;
        s2_valid    = imem_req_valid2;
        s2_addr     = imem_req_addr2;
        $display("t=%0t req=%0b addr=%h op=%0b pc=%h instr=%h", $time, s_req_valid, s_addr,
                 s_op_en, s_pc, s_instr);
        if (s_op_en) begin
            chk("deliver_pc", s_pc, exp_next_pc);
            chk("deliver_instr", s_instr, mem_data(s_pc));
            exp_next_pc = exp_next_pc + 32'd4;
        end else begin
            chk("idle_pc_instr_zero", s_pc | s_instr, 32'h0);
        end
        @(posedge clk);
        if (s_req_valid && imem_req_ready) pend.push_back(s_addr);
        if (imem_rsp_valid) void'(pend.pop_front());
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        rsp_en = 1'b1;
        pend.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_op_en", 32'(op_en_out), 32'h0);
        chk("rst_pc_instr", pc_out | instr_out, 32'h0);
        chk("rst2_req_addr", imem_req_addr2, 32'hFFFF_FFFC);
        reset = 1'b1;
        exp_next_pc = 32'h0;
    endtask

    task automatic wait_op(input string name, input logic [31:0] exp_pc);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_op_en && n < 20);
        chk(name, s_op_en ? s_pc : 32'hDEAD_BEEF, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Streaming after reset, then a 5-cycle stall with the memory ready throughout.
        vecs.push_back(mk(0, 1, 1, 32'h00, 0, 32'h00, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h04, 0, 32'h00, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h08, 1, 32'h00, INSTR_NOP));
        vecs.push_back(mk(0, 1, 1, 32'h08, 1, 32'h04, INSTR_NOP));
        vecs.push_back(mk(0, 1, 1, 32'h0C, 0, 32'h00, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h10, 1, 32'h08, INSTR_NOP));
        vecs.push_back(mk(0, 1, 1, 32'h10, 1, 32'h0C, INSTR_NOP));
        vecs.push_back(mk(1, 1, 1, 32'h14, 0, 32'h00, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h18, 0, 32'h00, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h18, 0, 32'h00, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h18, 0, 32'h00, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h18, 0, 32'h00, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h18, 1, 32'h10, INSTR_NOP));
        vecs.push_back(mk(0, 1, 1, 32'h18, 1, 32'h14, INSTR_NOP));
        vecs.push_back(mk(0, 1, 1, 32'h1C, 0, 32'h00, 32'h0));

        do_reset();
        for (int i = 0; i < vecs.size(); i++) begin
            stall = vecs[i].stall;
            imem_req_ready = vecs[i].ready;
            tick();
            chk($sformatf("vec%0d_req_valid", i), 32'(s_req_valid), 32'(vecs[i].req));
            chk($sformatf("vec%0d_req_addr", i), s_addr, vecs[i].addr);
            chk($sformatf("vec%0d_op_en", i), 32'(s_op_en), 32'(vecs[i].op));
            chk($sformatf("vec%0d_pc", i), s_pc, vecs[i].pc);
            chk($sformatf("vec%0d_instr", i), s_instr, vecs[i].instr);
        end

        // Memory not ready for 3 cycles while address 0x8 is pending.
        do_reset();
        repeat (3) tick();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_req_valid", 32'(s_req_valid), 32'h1);
            chk("hold_req_addr", s_addr, 32'h8);
        end
        imem_req_ready = 1'b1;
        tick();
        chk("hold_xfer_addr", s_addr, 32'h8);
        tick();
        chk("hold_next_valid", 32'(s_req_valid), 32'h1);
        chk("hold_next_addr", s_addr, 32'hC);

        // Redirect with two requests in flight: both responses dropped.
        do_reset();
        rsp_en = 1'b0;
        tick(); tick(); tick();
        chk("pre_redir_limit", 32'(s_req_valid), 32'h0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
        tick();
        chk("redir_no_req", 32'(s_req_valid), 32'h0);
        redirect_valid = 1'b0; rsp_en = 1'b1; exp_next_pc = 32'h1000;
        tick();
        chk("flush_no_req_a", 32'(s_req_valid), 32'h0);
        tick();
        chk("flush_no_req_b", 32'(s_req_valid), 32'h0);
        tick();
        chk("post_flush_valid", 32'(s_req_valid), 32'h1);
        chk("post_flush_addr", s_addr, 32'h1000);
        wait_op("first_pc_after_redir", 32'h1000);

        // Redirect while the buffer holds undelivered instructions.
        stall = 1'b1;
        repeat (4) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0043;
        tick();
        redirect_valid = 1'b0; stall = 1'b0; exp_next_pc = 32'h40;
        wait_op("buf_flush_pc", 32'h40);
        repeat (3) tick();

        // Second redirect during FLUSH wins.
        do_reset();
        rsp_en = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_1002;
        tick();
        redirect_pc = 32'h0000_2008;
        tick();
        chk("flush_redir_no_req", 32'(s_req_valid), 32'h0);
        redirect_valid = 1'b0; rsp_en = 1'b1; exp_next_pc = 32'h2008;
        tick();
        chk("flush2_no_req_a", 32'(s_req_valid), 32'h0);
        tick();
        chk("flush2_no_req_b", 32'(s_req_valid), 32'h0);
        tick();
        chk("flush2_addr", s_addr, 32'h2008);
        chk("flush2_valid", 32'(s_req_valid), 32'h1);
        wait_op("flush2_first_pc", 32'h2008);

        // Fetch address wraps from the top of memory.
        do_reset();
        rsp_en = 1'b0;
        tick();
        chk("wrap_req0_valid", 32'(s2_valid), 32'h1);
        chk("wrap_req0_addr", s2_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_req1_valid", 32'(s2_valid), 32'h1);
        chk("wrap_req1_addr", s2_addr, 32'h0000_0000);
        tick();
        chk("wrap_limit", 32'(s2_valid), 32'h0);
        chk("wrap_op_idle", 32'(op_en_out2) | pc_out2 | instr_out2, 32'h0);

        // Asynchronous reset in the middle of FLUSH.
        do_reset();
        rsp_en = 1'b0;
        tick(); tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("mid_flush_no_req", 32'(s_req_valid), 32'h0);
        chk("mid_flush_addr", s_addr, 32'h3000);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("async_rst_addr", imem_req_addr, 32'h0);
        chk("async_rst_op_en", 32'(op_en_out), 32'h0);
        chk("async_rst_pc_instr", pc_out | instr_out, 32'h0);
        @(posedge clk);
        #1;
        pend.delete();
        rsp_en = 1'b1;
        reset = 1'b1;
        exp_next_pc = 32'h0;
        tick();
        chk("restart_valid", 32'(s_req_valid), 32'h1);
        chk("restart_addr", s_addr, 32'h0);
        wait_op("restart_first_pc", 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
